seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Parametrised multi-digit, time-multiplexed 7-segment display driver with built-in hex decode.
- Latches a packed nibble vector and decimal-point mask through a load strobe; updates are applied only at frame boundaries, so a frame never mixes old and new values.
- Scans one digit per CLK_DIV cycles and drives the shared segment bus plus per-digit enables.
- Sits between core logic and board display pins.

Parameters:
- DIGITS, 4: number of digits scanned; legal range 1..8.
- CLK_DIV, 50000: clock cycles each digit is enabled; must be >= 2.
- SEG_ACTIVE_LOW, 1: 1 = segment outputs driven low-true; 0 = high-true.
- DIG_ACTIVE_LOW, 1: 1 = digit enables driven low-true; 0 = high-true.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- load  in  1  single-cycle strobe; captures value and dp_in into the pending register.
- value  in  4*DIGITS  packed nibbles; digit i = value[4i+3:4i]; digit 0 is the rightmost.
- dp_in  in  DIGITS  decimal-point request per digit.
- blank_lz  in  1  leading-zero blank request; only meaningful with the optional feature.
- seg  out  8  segments; bit0=a … bit6=g, bit7=dp; polarity set by SEG_ACTIVE_LOW.
- an  out  DIGITS  digit enables, exactly one active at a time; polarity set by DIG_ACTIVE_LOW.
- frame_done  out  1  one-cycle pulse on the cycle after digit DIGITS-1 finishes.

Behaviour:
- Reset:
  - prescaler=0, digit index=0.
  - active and pending registers = 0, pending_valid=0.
  - seg = all segments off; an = all digits off; frame_done=0.
  - "Off" always means the inactive level for the configured polarity.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - tick is asserted when count==CLK_DIV-1.
- Digit index:
  - Advances on tick; wraps from DIGITS-1 to 0.
  - The wrap cycle is the frame boundary.
- Frame boundary (tick with index==DIGITS-1):
  - frame_done=1 on the next cycle, for one cycle.
  - If pending_valid, copy pending into active and clear pending_valid.
- load:
  - Writes value/dp_in into pending and sets pending_valid.
  - A later load before the boundary overwrites pending; last write wins.
  - load on the boundary cycle bypasses pending: the value goes directly to active for the new frame.
- Outputs are registered with 1-cycle latency from index/active.
  - Each digit is enabled for exactly CLK_DIV consecutive cycles.
  - The first cycle after rst deasserts shows digit 0.
- Decode, hex glyphs, true polarity before inversion:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - dp = active dp bit of the current digit.
- Inversion:
  - Segment inversion is applied when SEG_ACTIVE_LOW=1.
  - Enable inversion is applied when DIG_ACTIVE_LOW=1.
- Reset mid-frame: outputs go off on the next cycle; pending and active data are discarded.
- value/dp_in are sampled only on load; changes without load have no effect.

Optional Feature:
- Macro: SEG7_LZ_BLANK_EN
- Defined:
  - When blank_lz=1, digit i (i>0) has glyph segments forced off if its nibble and every higher nibble in active are zero.
  - dp still follows dp_in.
  - Digit 0 is never blanked.
  - an scanning is unchanged.
- Undefined: blank_lz is ignored; all digits are always decoded.

Test Plan:
All cases use DIGITS=4, CLK_DIV=4, both polarities low-true.
- Reset hold, then release:
  - During rst: an=4'b1111, seg=8'hFF.
  - First cycle after release: an=4'b1110, seg=8'hC0 ("0").
  - an rotates 1110→1101→1011→0111, 4 cycles each.
- load value=16'h12AB, dp_in=0 mid-frame:
  - Display is unchanged until the frame boundary.
  - Next frame: digit0 seg=8'h83, digit1 8'h88, digit2 8'hA4, digit3 8'hF9.
- Free run: frame_done high for exactly 1 cycle every 16 cycles. Two loads in one frame: only the second is displayed. load on the boundary cycle: shown in the immediately following frame.
- dp_in=4'b0100 with value=16'h2222: digit2 seg=8'h24, other digits 8'hA4.
- rst asserted during digit 2 of a frame with a pending load: next cycle all off; after release, display shows 0 on all digits.
- SEG7_LZ_BLANK_EN defined, blank_lz=1:
  - value=16'h0050 → digit3/digit2 seg=8'hFF, digit1 8'h92, digit0 8'hC0.
  - value=16'h0000 → only digit0 shows 8'hC0.
  - Macro undefined, value 16'h0050 → digit3 and digit2 show 8'hC0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex 7-segment driver: one digit per CLK_DIV cycles, new data taken only at frame boundaries.
// Optional leading-zero blanking is compiled in with `define SEG7_LZ_BLANK_EN.
module seg7_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int CLK_DIV        = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = $clog2(CLK_DIV);
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [7:0]        SEG_INV  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] DIG_INV  = {DIGITS{DIG_ACTIVE_LOW != 0}};

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'h3F;
            4'h1:    g = 7'h06;
            4'h2:    g = 7'h5B;
            4'h3:    g = 7'h4F;
            4'h4:    g = 7'h66;
            4'h5:    g = 7'h6D;
            4'h6:    g = 7'h7D;
            4'h7:    g = 7'h07;
            4'h8:    g = 7'h7F;
            4'h9:    g = 7'h6F;
            4'hA:    g = 7'h77;
            4'hB:    g = 7'h7C;
            4'hC:    g = 7'h39;
            4'hD:    g = 7'h5E;
            4'hE:    g = 7'h79;
            4'hF:    g = 7'h71;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    logic [PRE_W-1:0]    r_pre;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_act_val;
    logic [DIGITS-1:0]   r_act_dp;
    logic [4*DIGITS-1:0] r_pend_val;
    logic [DIGITS-1:0]   r_pend_dp;
    logic                r_pend_valid;
    logic [7:0]          r_seg;
    logic [DIGITS-1:0]   r_an;
    logic                r_frame_done;

    logic                w_tick;
    logic                w_boundary;
    logic [DIGITS-1:0]   w_an_true;
    logic [3:0]          w_nib;
    logic                w_dp;
    logic                w_blank;
    logic [6:0]          w_glyph;

    assign w_tick     = (r_pre == PRE_LAST);
    assign w_boundary = w_tick & (r_idx == IDX_LAST);

    // Prescaler and digit index; the index wrap is the frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    // Pending/active data: a load on the boundary cycle goes straight to the new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_act_val    <= '0;
            r_act_dp     <= '0;
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pend_valid <= 1'b0;
        end else if (w_boundary) begin
            if (load) begin
                r_act_val <= value;
                r_act_dp  <= dp_in;
            end else if (r_pend_valid) begin
                r_act_val <= r_pend_val;
                r_act_dp  <= r_pend_dp;
            end else begin
                r_act_val <= r_act_val;
                r_act_dp  <= r_act_dp;
            end
            r_pend_valid <= 1'b0;
        end else if (load) begin
            r_pend_val   <= value;
            r_pend_dp    <= dp_in;
            r_pend_valid <= 1'b1;
        end else begin
            r_pend_valid <= r_pend_valid;
        end
    end

    // Current digit select, its nibble and its decimal point.
    always_comb begin
        w_an_true = '0;
        w_nib     = 4'h0;
        w_dp      = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            w_an_true[i] = (r_idx == IDX_W'(i));
            w_nib        = w_nib | (w_an_true[i] ? r_act_val[4*i +: 4] : 4'h0);
            w_dp         = w_dp | (w_an_true[i] & r_act_dp[i]);
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    logic [DIGITS-1:0] w_hi_zero;
    logic              w_run_zero;

    // w_hi_zero[i]: nibble i and every higher nibble are zero.
    always_comb begin
        w_hi_zero  = '0;
        w_run_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_run_zero   = w_run_zero & (r_act_val[4*i +: 4] == 4'h0);
            w_hi_zero[i] = w_run_zero;
        end
    end

    assign w_blank = blank_lz & (|(w_an_true & w_hi_zero)) & (r_idx != '0);
`else
    logic w_unused_blank_lz;
    assign w_unused_blank_lz = blank_lz;
    assign w_blank           = 1'b0;
`endif

    assign w_glyph = hex_glyph(w_nib) & {7{~w_blank}};

    // Registered pin drivers with polarity applied; off is the inactive level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg        <= SEG_INV;
            r_an         <= DIG_INV;
            r_frame_done <= 1'b0;
        end else begin
            r_seg        <= {w_dp, w_glyph} ^ SEG_INV;
            r_an         <= w_an_true ^ DIG_INV;
            r_frame_done <= w_boundary;
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (DIGITS=4, CLK_DIV=4, low-true segments and enables).
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic        blank_lz = 1'b0;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    seg7_scan_driver #(
        .DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
        .blank_lz(blank_lz), .seg(seg), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] an;
        logic       fd;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [6:0] glyph_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // reference model state; k counts edges since reset release
    int          k = 0;
    logic [15:0] m_act = 16'h0, m_pend = 16'h0;
    logic [3:0]  m_adp = 4'h0, m_pdp = 4'h0;
    bit          m_pv = 1'b0;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // One clock: push expectation for this edge, update model, then pop and compare.
    task automatic step();
        exp_t e;
        exp_t got;
        int   d;
        logic [3:0] nib;
        logic [6:0] g;
        bit   blank;
        if (rst) begin
            e = '{seg: 8'hFF, an: 4'hF, fd: 1'b0};
        end else begin
            d   = (k / 4) % 4;
            nib = m_act[4*d +: 4];
            blank = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
            if (blank_lz && d > 0) begin
                blank = 1'b1;
                for (int j = d; j < 4; j++)
                    if (m_act[4*j +: 4] != 4'h0) blank = 1'b0;
            end
`endif
            g = blank ? 7'h00 : glyph_tbl[nib];
            e.seg = ~{m_adp[d], g};
            e.an  = ~(4'b0001 << d);
            e.fd  = ((k % 16) == 15);
        end
        sb_q.push_back(e);
        if (rst) begin
            k = 0; m_act = '0; m_pend = '0; m_adp = '0; m_pdp = '0; m_pv = 1'b0;
        end else begin
            if ((k % 16) == 15) begin
                if (load) begin
                    m_act = value; m_adp = dp_in;
                end else if (m_pv) begin
                    m_act = m_pend; m_adp = m_pdp;
                end
                m_pv = 1'b0;
            end else if (load) begin
                m_pend = value; m_pdp = dp_in; m_pv = 1'b1;
            end
            k++;
        end
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check_eq("seg", {8'h00, seg}, {8'h00, got.seg});
        check_eq("an", {12'h000, an}, {12'h000, got.an});
        check_eq("frame_done", {15'h0, frame_done}, {15'h0, got.fd});
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until the next edge is frame position pos (at most 16 clocks).
    task automatic run_until(input int pos);
        for (int i = 0; i < 16 && (k % 16) != pos; i++) step();
    endtask

    task automatic load_one(input logic [15:0] v, input logic [3:0] dp);
        value = v; dp_in = dp; load = 1'b1;
        step();
        load = 1'b0; value = $urandom; dp_in = $urandom;
    endtask

    initial begin
        // reset hold
        steps(3);
        check_eq("rst_an", {12'h0, an}, 16'h000F);
        check_eq("rst_seg", {8'h0, seg}, 16'h00FF);

        // release: digit 0 showing "0" straight away, then rotation
        rst = 1'b0;
        step();
        check_eq("first_an", {12'h0, an}, 16'h000E);
        check_eq("first_seg", {8'h0, seg}, 16'h00C0);
        run_until(4); step();
        check_eq("rot_an1", {12'h0, an}, 16'h000D);
        run_until(12); step();
        check_eq("rot_an3", {12'h0, an}, 16'h0007);

        // mid-frame load: unchanged until boundary
        run_until(5);
        load_one(16'h12AB, 4'h0);
        run_until(12); step();
        check_eq("hold_d3", {8'h0, seg}, 16'h00C0);
        run_until(0); step();
        check_eq("12AB_d0", {8'h0, seg}, 16'h0083);
        run_until(4); step();
        check_eq("12AB_d1", {8'h0, seg}, 16'h0088);
        run_until(8); step();
        check_eq("12AB_d2", {8'h0, seg}, 16'h00A4);
        run_until(12); step();
        check_eq("12AB_d3", {8'h0, seg}, 16'h00F9);

        // two loads in one frame: last one wins
        run_until(3);
        load_one(16'h1111, 4'h0);
        run_until(9);
        load_one(16'h3333, 4'h0);
        run_until(0); step();
        check_eq("last_wins", {8'h0, seg}, 16'h00B0);

        // load on the boundary cycle
        run_until(15);
        load_one(16'h5555, 4'h0);
        check_eq("bnd_fd", {15'h0, frame_done}, 16'h0001);
        step();
        check_eq("bnd_load", {8'h0, seg}, 16'h0092);

        // decimal point on digit 2
        run_until(6);
        load_one(16'h2222, 4'b0100);
        run_until(4); step();
        check_eq("dp_d1", {8'h0, seg}, 16'h00A4);
        run_until(8); step();
        check_eq("dp_d2", {8'h0, seg}, 16'h0024);

        // reset during digit 2 with a pending load
        run_until(2);
        load_one(16'h7777, 4'hF);
        run_until(9);
        rst = 1'b1;
        step();
        check_eq("mid_rst_an", {12'h0, an}, 16'h000F);
        check_eq("mid_rst_seg", {8'h0, seg}, 16'h00FF);
        rst = 1'b0;
        steps(16);
        check_eq("post_rst_seg", {8'h0, seg}, 16'h00C0);

        // leading-zero blanking request
        blank_lz = 1'b1;
        run_until(4);
        load_one(16'h0050, 4'h0);
        run_until(4); step();
        check_eq("lz_d1", {8'h0, seg}, 16'h0092);
        run_until(12); step();
`ifdef SEG7_LZ_BLANK_EN
        check_eq("lz_d3", {8'h0, seg}, 16'h00FF);
`else
        check_eq("lz_d3", {8'h0, seg}, 16'h00C0);
`endif
        run_until(4);
        load_one(16'h0000, 4'h0);
        run_until(0); step();
        check_eq("lz0_d0", {8'h0, seg}, 16'h00C0);

        // free run with random inputs but no load
        blank_lz = 1'b0;
        steps(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
